// File: rtl/network_if_pkg.sv
// rtl/network_if_pkg.sv - shared network-interface flit types, default widths and pack offsets
package network_if_pkg;

    localparam int NETWORK_IF_FLIT_WIDTH            = 64;
    localparam int NETWORK_IF_FLIT_TYPE_WIDTH       = 2;
    localparam int NETWORK_IF_BROADCAST_WIDTH       = 1;
    localparam int NETWORK_IF_VIRTUAL_NETWORK_WIDTH = 2;
    localparam int NETWORK_IF_NUM_VIRTUAL_NETWORKS  = 3;

    // Packing is {vn_id, broadcast, flit_type, flit} with the flit in the LSBs.
    localparam int FLIT_LSB      = 0;
    localparam int FLIT_TYPE_LSB = FLIT_LSB + NETWORK_IF_FLIT_WIDTH;
    localparam int BROADCAST_LSB = FLIT_TYPE_LSB + NETWORK_IF_FLIT_TYPE_WIDTH;
    localparam int VN_LSB        = BROADCAST_LSB + NETWORK_IF_BROADCAST_WIDTH;

    localparam logic [1:0] FLIT_TYPE_HEADER      = 2'b00;
    localparam logic [1:0] FLIT_TYPE_PAYLOAD     = 2'b01;
    localparam logic [1:0] FLIT_TYPE_TAIL        = 2'b10;
    localparam logic [1:0] FLIT_TYPE_HEADER_TAIL = 2'b11;

    typedef enum logic {
        CHK_IDLE,
        CHK_IN_PACKET
    } chk_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - in-order synchronous FIFO with occupancy counter, power-of-two depth
module sync_fifo #(
    parameter int DataWidth = 8,
    parameter int Depth     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DataWidth-1:0] din,
    output logic [DataWidth-1:0] dout,
    output logic                 full,
    output logic                 empty
);

    localparam int PtrWidth = $clog2(Depth);

    logic [DataWidth-1:0] mem [Depth];
    logic [PtrWidth-1:0]  wr_ptr;
    logic [PtrWidth-1:0]  rd_ptr;
    logic [PtrWidth:0]    count;
    logic                 do_push;
    logic                 do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == (PtrWidth+1)'(Depth));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/network_injector.sv
// rtl/network_injector.sv - source-to-NoC flit injector; optional checker under NETWORK_INJECTOR_PROTOCOL_CHECK_EN
module network_injector
    import network_if_pkg::*;
#(
    parameter int NetworkIfFlitWidth             = NETWORK_IF_FLIT_WIDTH,
    parameter int NetworkIfFlitTypeWidth         = NETWORK_IF_FLIT_TYPE_WIDTH,
    parameter int NetworkIfBroadcastWidth        = NETWORK_IF_BROADCAST_WIDTH,
    parameter int NetworkIfVirtualNetworkIdWidth = NETWORK_IF_VIRTUAL_NETWORK_WIDTH,
    parameter int NetworkIfNumberOfVirtualNetworks = NETWORK_IF_NUM_VIRTUAL_NETWORKS,
    parameter int BufferDepth                    = 2,
    localparam int NetworkIfDataWidth = NetworkIfFlitWidth + NetworkIfFlitTypeWidth +
                                        NetworkIfBroadcastWidth + NetworkIfVirtualNetworkIdWidth
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        valid_i,
    output logic                                        ready_o,
    input  logic [NetworkIfDataWidth-1:0]               data_i,
    output logic                                        network_valid_o,
    input  logic [NetworkIfNumberOfVirtualNetworks-1:0] network_ready_i,
    output logic [NetworkIfFlitWidth-1:0]               network_flit_o,
    output logic [NetworkIfFlitTypeWidth-1:0]           network_flit_type_o,
    output logic [NetworkIfBroadcastWidth-1:0]          network_broadcast_o,
    output logic [NetworkIfVirtualNetworkIdWidth-1:0]   network_virtual_network_id_o,
    output logic                                        protocol_error_o
);

    localparam int TypeLsb  = NetworkIfFlitWidth;
    localparam int BcastLsb = TypeLsb + NetworkIfFlitTypeWidth;
    localparam int VnLsb    = BcastLsb + NetworkIfBroadcastWidth;

    logic                                      push;
    logic                                      pop;
    logic                                      full;
    logic                                      empty;
    logic                                      head_avail;
    logic [NetworkIfDataWidth-1:0]             head;
    logic [NetworkIfDataWidth-1:0]             last_popped;
    logic [NetworkIfDataWidth-1:0]             shown;
    logic [NetworkIfVirtualNetworkIdWidth-1:0] head_vn;

    assign ready_o = !full && !rst_i;
    assign push    = valid_i && ready_o;
    assign pop     = network_valid_o;

    sync_fifo #(
        .DataWidth (NetworkIfDataWidth),
        .Depth     (BufferDepth)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .din   (data_i),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign head_vn = head[VnLsb +: NetworkIfVirtualNetworkIdWidth];

    // An out-of-range head VN matches no avail bit, so it stalls the FIFO until reset.
    always_comb begin
        head_avail = 1'b0;
        for (int i = 0; i < NetworkIfNumberOfVirtualNetworks; i++) begin
            if (int'(head_vn) == i) begin
                head_avail = network_ready_i[i];
            end
        end
    end

    // Avail is not registered: valid follows network_ready_i combinationally.
    assign network_valid_o = !empty && !rst_i && head_avail;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_popped <= '0;
        end else if (pop) begin
            last_popped <= head;
        end
    end

    assign shown                        = empty ? last_popped : head;
    assign network_flit_o               = shown[0 +: NetworkIfFlitWidth];
    assign network_flit_type_o          = shown[TypeLsb +: NetworkIfFlitTypeWidth];
    assign network_broadcast_o          = shown[BcastLsb +: NetworkIfBroadcastWidth];
    assign network_virtual_network_id_o = shown[VnLsb +: NetworkIfVirtualNetworkIdWidth];

`ifdef NETWORK_INJECTOR_PROTOCOL_CHECK_EN
    chk_state_e                                chk_state;
    chk_state_e                                chk_next;
    logic [NetworkIfVirtualNetworkIdWidth-1:0] hdr_vn;
    logic [NetworkIfVirtualNetworkIdWidth-1:0] hdr_vn_next;
    logic [NetworkIfVirtualNetworkIdWidth-1:0] in_vn;
    logic [NetworkIfFlitTypeWidth-1:0]         in_type;
    logic                                      chk_err;
    logic                                      protocol_error;

    assign in_vn   = data_i[VnLsb +: NetworkIfVirtualNetworkIdWidth];
    assign in_type = data_i[TypeLsb +: NetworkIfFlitTypeWidth];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chk_state      <= CHK_IDLE;
            hdr_vn         <= '0;
            protocol_error <= 1'b0;
        end else begin
            chk_state      <= chk_next;
            hdr_vn         <= hdr_vn_next;
            protocol_error <= protocol_error | chk_err;
        end
    end

    always_comb begin
        chk_next    = chk_state;
        hdr_vn_next = hdr_vn;
        chk_err     = 1'b0;
        if (push) begin
            if (int'(in_vn) >= NetworkIfNumberOfVirtualNetworks) begin
                chk_err = 1'b1;
            end else begin
                case (chk_state)
                    CHK_IDLE: begin
                        if (in_type == FLIT_TYPE_HEADER) begin
                            chk_next    = CHK_IN_PACKET;
                            hdr_vn_next = in_vn;
                        end else if (in_type != FLIT_TYPE_HEADER_TAIL) begin
                            chk_err = 1'b1;
                        end
                    end
                    CHK_IN_PACKET: begin
                        if (in_vn != hdr_vn) begin
                            chk_err = 1'b1;
                        end else if (in_type == FLIT_TYPE_TAIL) begin
                            chk_next = CHK_IDLE;
                        end else if (in_type != FLIT_TYPE_PAYLOAD) begin
                            chk_err = 1'b1;
                        end
                    end
                    default: chk_err = 1'b1;
                endcase
            end
            // The offending flit is still buffered; only the checker resynchronises.
            if (chk_err) begin
                chk_next = CHK_IDLE;
            end
        end
    end

    assign protocol_error_o = protocol_error;
`else
    assign protocol_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_network_injector.sv
// tb/tb_network_injector.sv - self-checking bench for network_injector against a queue reference model
module tb_network_injector;

    localparam int DW = 69;
    localparam logic [1:0] T_H  = 2'b00;
    localparam logic [1:0] T_P  = 2'b01;
    localparam logic [1:0] T_T  = 2'b10;
    localparam logic [1:0] T_HT = 2'b11;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] data_i;
    logic          network_valid_o;
    logic [2:0]    network_ready_i;
    logic [63:0]   network_flit_o;
    logic [1:0]    network_flit_type_o;
    logic [0:0]    network_broadcast_o;
    logic [1:0]    network_virtual_network_id_o;
    logic          protocol_error_o;

    network_injector dut (
        .clk_i                        (clk_i),
        .rst_i                        (rst_i),
        .valid_i                      (valid_i),
        .ready_o                      (ready_o),
        .data_i                       (data_i),
        .network_valid_o              (network_valid_o),
        .network_ready_i              (network_ready_i),
        .network_flit_o               (network_flit_o),
        .network_flit_type_o          (network_flit_type_o),
        .network_broadcast_o          (network_broadcast_o),
        .network_virtual_network_id_o (network_virtual_network_id_o),
        .protocol_error_o             (protocol_error_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int dut_pops = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] txq[$];
    logic [DW-1:0] m_last;
    bit            m_err;
    bit            m_inpkt;
    logic [1:0]    m_hvn;
    bit            m_acc;

    function automatic logic [DW-1:0] pack(input logic [1:0] vn, input logic b,
                                           input logic [1:0] t, input logic [63:0] f);
        return {vn, b, t, f};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packet grammar applied to each accepted flit.
    task automatic proto_model(input logic [DW-1:0] d);
        logic [1:0] vn;
        logic [1:0] t;
        bit bad;
        vn  = d[68:67];
        t   = d[65:64];
        bad = 0;
        if (vn > 2'd2) bad = 1;
        else if (!m_inpkt) begin
            if (t == T_H) begin m_inpkt = 1; m_hvn = vn; end
            else if (t != T_HT) bad = 1;
        end else begin
            if (vn != m_hvn || !(t == T_P || t == T_T)) bad = 1;
            else if (t == T_T) m_inpkt = 0;
        end
        if (bad) begin m_err = 1; m_inpkt = 0; end
    endtask

    task automatic step(input logic vi, input logic [DW-1:0] d, input logic [2:0] nr, input logic r);
        logic [DW-1:0] hd;
        logic exp_ready;
        logic exp_valid;
        logic exp_err;
        valid_i = vi;
        data_i = d;
        network_ready_i = nr;
        rst_i = r;
        #1;
        exp_ready = (mq.size() < 2) && !r;
        hd = (mq.size() > 0) ? mq[0] : m_last;
        exp_valid = !r && (mq.size() > 0) && (hd[68:67] < 2'd3) && nr[hd[68:67]];
`ifdef NETWORK_INJECTOR_PROTOCOL_CHECK_EN
        exp_err = m_err;
`else
        exp_err = 1'b0;
`endif
        check("ready_o", ready_o, exp_ready);
        check("network_valid_o", network_valid_o, exp_valid);
        check("network_flit_o", network_flit_o, hd[63:0]);
        check("network_flit_type_o", network_flit_type_o, hd[65:64]);
        check("network_broadcast_o", network_broadcast_o, hd[66]);
        check("network_vn_o", network_virtual_network_id_o, hd[68:67]);
        check("protocol_error_o", protocol_error_o, exp_err);
        if (network_valid_o === 1'b1) dut_pops++;
        @(posedge clk_i);
        m_acc = 0;
        if (r) begin
            mq.delete();
            m_last = '0;
            m_err = 0;
            m_inpkt = 0;
        end else begin
            if (exp_valid) m_last = mq.pop_front();
            if (vi && exp_ready) begin
                proto_model(d);
                mq.push_back(d);
                m_acc = 1;
            end
        end
        #1;
    endtask

    task automatic run(input int n, input logic [2:0] nr);
        for (int k = 0; k < n; k++) begin
            if (txq.size() > 0) step(1'b1, txq[0], nr, 1'b0);
            else step(1'b0, '0, nr, 1'b0);
            if (m_acc) void'(txq.pop_front());
        end
    endtask

    initial begin
        int p0;
        logic [1:0] rvn;
        logic [63:0] rf;
        logic rr;
        valid_i = 0;
        data_i = '0;
        network_ready_i = '0;
        rst_i = 1;
        repeat (2) @(posedge clk_i);
        #1;
        m_last = '0;
        m_err = 0;
        m_inpkt = 0;
        m_hvn = '0;
        step(1'b0, '0, 3'b000, 1'b1);

        // Single HEADER_TAIL on vn 1
        step(1'b1, pack(2'd1, 1'b0, T_HT, 64'hDEAD_BEEF), 3'b010, 1'b0);
        check("ht_latency_valid", network_valid_o, 1'b1);
        check("ht_latency_flit", network_flit_o, 64'hDEAD_BEEF);
        step(1'b0, '0, 3'b010, 1'b0);
        step(1'b0, '0, 3'b010, 1'b0);

        // 4-flit packet stalled on vn 0, then drained
        txq.push_back(pack(2'd0, 1'b0, T_H, 64'h10));
        txq.push_back(pack(2'd0, 1'b0, T_P, 64'h11));
        txq.push_back(pack(2'd0, 1'b0, T_P, 64'h12));
        txq.push_back(pack(2'd0, 1'b0, T_T, 64'h13));
        run(4, 3'b000);
        check("pkt_full_ready", ready_o, 1'b0);
        p0 = dut_pops;
        run(8, 3'b001);
        check("pkt_pops", dut_pops - p0, 4);

        // Head-of-line blocking
        txq.push_back(pack(2'd2, 1'b1, T_HT, 64'h20));
        txq.push_back(pack(2'd0, 1'b0, T_HT, 64'h21));
        run(4, 3'b011);
        check("hol_blocked", network_valid_o, 1'b0);
        p0 = dut_pops;
        run(4, 3'b111);
        check("hol_released_pops", dut_pops - p0, 2);

        // Full FIFO then sustained drain
        for (int i = 0; i < 8; i++)
            txq.push_back(pack(2'($urandom_range(0, 2)), 1'($urandom), T_HT, {$urandom, $urandom}));
        run(3, 3'b000);
        p0 = dut_pops;
        run(14, 3'b111);
        check("stream_pops", dut_pops - p0, 8);

        // Reset with two buffered flits
        txq.push_back(pack(2'd1, 1'b0, T_HT, 64'h30));
        txq.push_back(pack(2'd1, 1'b0, T_HT, 64'h31));
        run(3, 3'b000);
        step(1'b0, '0, 3'b000, 1'b1);
        p0 = dut_pops;
        step(1'b0, '0, 3'b111, 1'b0);
        step(1'b0, '0, 3'b111, 1'b0);
        check("post_reset_pops", dut_pops - p0, 0);
        check("post_reset_ready", ready_o, 1'b1);

        // PAYLOAD while idle
        step(1'b1, pack(2'd0, 1'b0, T_P, 64'h40), 3'b111, 1'b0);
`ifdef NETWORK_INJECTOR_PROTOCOL_CHECK_EN
        check("perr_set", protocol_error_o, 1'b1);
`else
        check("perr_tied", protocol_error_o, 1'b0);
`endif
        repeat (3) step(1'b0, '0, 3'b111, 1'b0);

        // Randomized traffic with occasional out-of-range VN and resets
        for (int i = 0; i < 400; i++) begin
            rvn = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rf = {$urandom, $urandom};
            rr = ($urandom_range(0, 39) == 0);
            step(1'($urandom), pack(rvn, 1'($urandom), 2'($urandom), rf),
                 rr ? 3'b000 : 3'($urandom), rr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
